// File: rtl/usb_bit_stuffer_tx.sv
// usb_bit_stuffer_tx
//   Transmit-side USB bit stuffer and NRZI line encoder. Takes an LSB-first
//   packet bit stream (SYNC..CRC) one bit per bit-time. After STUFF_LIMIT
//   consecutive 1s it inserts a 0. The result is NRZI-encoded onto D+/D-,
//   and the packet is closed with an EOP (SE0 x EOP_SE0_BITS, then J).
// Ports:
//   clk, RST         clock, synchronous active-high reset
//   bit_en           one-clk strobe per bit-time; qualifies every transfer
//   in_bit/in_valid  serial data bit and its valid flag
//   in_last          marks in_bit as the final packet bit
//   in_ready         combinational; low on stuff slots, after in_last and in RST
//   out_dp/dm/oe     registered line levels and driver enable
//   busy             high while a packet is in flight
//   tx_err           one-clk pulse on underrun (packet aborted with EOP)
//   one_count        current run of transmitted 1s
module usb_bit_stuffer_tx #(
  parameter int unsigned STUFF_LIMIT  = 6,
  parameter int unsigned EOP_SE0_BITS = 2,
  parameter int unsigned CNT_W        = $clog2(STUFF_LIMIT + 1)
) (
  input  logic             clk,
  input  logic             RST,
  input  logic             bit_en,
  input  logic             in_bit,
  input  logic             in_valid,
  input  logic             in_last,
  output logic             in_ready,
  output logic             out_dp,
  output logic             out_dm,
  output logic             out_oe,
  output logic             busy,
  output logic             tx_err,
  output logic [CNT_W-1:0] one_count
);

  localparam int unsigned EW = $clog2(EOP_SE0_BITS + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DATA,
    S_STUFF,
    S_EOP_SE0,
    S_EOP_J
  } state_t;

  state_t           state_q, state_d;
  logic             dp_q, dp_d;
  logic             dm_q, dm_d;
  logic             oe_q, oe_d;
  logic             busy_q, busy_d;
  logic             err_q, err_d;
  logic             last_q, last_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [EW-1:0]    eop_q, eop_d;

  logic             xfer;
  logic [CNT_W-1:0] cnt_new;

  assign in_ready = ~RST & ((state_q == S_IDLE) | (state_q == S_DATA)) & ~last_q;
  assign xfer     = in_valid & in_ready & bit_en;
  assign cnt_new  = in_bit ? (cnt_q + CNT_W'(1)) : '0;

  always_comb begin
    state_d = state_q;
    dp_d    = dp_q;
    dm_d    = dm_q;
    oe_d    = oe_q;
    busy_d  = busy_q;
    err_d   = 1'b0;
    last_d  = last_q;
    cnt_d   = cnt_q;
    eop_d   = eop_q;

    if (bit_en) begin
      unique case (state_q)
        S_IDLE, S_DATA: begin
          if (xfer) begin
            // dp_q is the last driven J/K level (J while idle), so NRZI
            // keeps the level for a 1 and toggles it for a 0.
            dp_d   = in_bit ? dp_q : ~dp_q;
            dm_d   = in_bit ? ~dp_q : dp_q;
            oe_d   = 1'b1;
            busy_d = 1'b1;
            cnt_d  = cnt_new;
            last_d = in_last;
            eop_d  = '0;
            if (cnt_new == CNT_W'(STUFF_LIMIT)) begin
              state_d = S_STUFF;
            end else if (in_last) begin
              state_d = S_EOP_SE0;
            end else begin
              state_d = S_DATA;
            end
          end else if (state_q == S_DATA) begin
            // Underrun: hold the line this slot and abort with an EOP.
            err_d   = 1'b1;
            state_d = S_EOP_SE0;
            eop_d   = '0;
          end else begin
            oe_d   = 1'b0;
            dp_d   = 1'b1;
            dm_d   = 1'b0;
            busy_d = 1'b0;
            cnt_d  = '0;
            last_d = 1'b0;
          end
        end
        S_STUFF: begin
          dp_d    = ~dp_q;
          dm_d    = dp_q;
          cnt_d   = '0;
          eop_d   = '0;
          state_d = last_q ? S_EOP_SE0 : S_DATA;
        end
        S_EOP_SE0: begin
          dp_d  = 1'b0;
          dm_d  = 1'b0;
          cnt_d = '0;
          if (eop_q == EW'(EOP_SE0_BITS - 1)) begin
            state_d = S_EOP_J;
            eop_d   = '0;
          end else begin
            eop_d = eop_q + EW'(1);
          end
        end
        S_EOP_J: begin
          // Two strobes here: the first drives J, the second releases the line.
          if (eop_q == '0) begin
            dp_d  = 1'b1;
            dm_d  = 1'b0;
            eop_d = EW'(1);
          end else begin
            oe_d    = 1'b0;
            busy_d  = 1'b0;
            last_d  = 1'b0;
            eop_d   = '0;
            state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (RST) begin
      state_q <= S_IDLE;
      dp_q    <= 1'b1;
      dm_q    <= 1'b0;
      oe_q    <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
      last_q  <= 1'b0;
      cnt_q   <= '0;
      eop_q   <= '0;
    end else begin
      state_q <= state_d;
      dp_q    <= dp_d;
      dm_q    <= dm_d;
      oe_q    <= oe_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      eop_q   <= eop_d;
    end
  end

  assign out_dp    = dp_q;
  assign out_dm    = dm_q;
  assign out_oe    = oe_q;
  assign busy      = busy_q;
  assign tx_err    = err_q;
  assign one_count = cnt_q;

endmodule

// File: tb/tb_usb_bit_stuffer_tx.sv
module tb_usb_bit_stuffer_tx;

  logic       clk;
  logic       RST;
  logic       bit_en;
  logic       in_bit;
  logic       in_valid;
  logic       in_last;
  logic       in_ready;
  logic       out_dp;
  logic       out_dm;
  logic       out_oe;
  logic       busy;
  logic       tx_err;
  logic [2:0] one_count;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic       rdy;
    logic       oe;
    logic       dp;
    logic       dm;
    logic       err;
    logic       bsy;
    logic       chk_cnt;
    logic [2:0] cnt;
  } exp_t;

  exp_t exp_q[$];

  usb_bit_stuffer_tx #(.STUFF_LIMIT(6), .EOP_SE0_BITS(2)) dut (
    .clk       (clk),
    .RST       (RST),
    .bit_en    (bit_en),
    .in_bit    (in_bit),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .out_dp    (out_dp),
    .out_dm    (out_dm),
    .out_oe    (out_oe),
    .busy      (busy),
    .tx_err    (tx_err),
    .one_count (one_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic push(input logic rdy, input logic oe, input logic dp, input logic dm,
                      input logic err, input logic bsy, input logic chk, input int c);
    exp_t e;
    e.rdy = rdy; e.oe = oe; e.dp = dp; e.dm = dm;
    e.err = err; e.bsy = bsy; e.chk_cnt = chk; e.cnt = 3'(c);
    exp_q.push_back(e);
  endtask

  // Bit-level reference: one queue entry per bit_en slot of the packet.
  task automatic build_expected(input logic [31:0] bits, input int n, input bit underrun);
    logic lvl;
    int   c;
    lvl = 1'b1;
    c   = 0;
    for (int i = 0; i < n; i++) begin
      if (bits[i]) c++;
      else begin lvl = ~lvl; c = 0; end
      push(1, 1, lvl, ~lvl, 0, 1, 1, c);
      if (c == 6) begin
        lvl = ~lvl;
        c   = 0;
        push(0, 1, lvl, ~lvl, 0, 1, 1, 0);
      end
    end
    if (underrun) push(1, 1, lvl, ~lvl, 1, 1, 0, 0);
    push(0, 1, 0, 0, 0, 1, 0, 0);
    push(0, 1, 0, 0, 0, 1, 0, 0);
    push(0, 1, 1, 0, 0, 1, 0, 0);
    push(0, 0, 1, 0, 0, 0, 1, 0);
  endtask

  task automatic run_pkt(input string name, input logic [31:0] bits, input int n,
                         input bit underrun, input int period);
    int   idx;
    int   cyc;
    bit   be;
    bit   acc;
    exp_t e;
    logic [2:0] prev;
    build_expected(bits, n, underrun);
    idx  = 0;
    cyc  = 0;
    prev = 3'b010;
    while (exp_q.size() > 0 && cyc < 2000) begin
      be = (cyc % period) == 0;
      @(negedge clk);
      bit_en   = be;
      in_valid = (idx < n);
      in_bit   = (idx < n) ? bits[idx] : 1'b0;
      in_last  = !underrun && (idx == n - 1);
      #1;
      acc = 1'b0;
      e   = exp_q[0];
      if (be) begin
        checks++;
        if (in_ready !== e.rdy) begin
          errors++;
          $display("FAIL %s in_ready slot%0d: got %b want %b", name, cyc, in_ready, e.rdy);
        end
        acc = in_ready && (idx < n);
      end
      @(posedge clk);
      #1;
      if (be) begin
        void'(exp_q.pop_front());
        checks++;
        if ({out_oe, out_dp, out_dm} !== {e.oe, e.dp, e.dm}) begin
          errors++;
          $display("FAIL %s line cyc%0d: got oe/dp/dm %b%b%b want %b%b%b", name, cyc,
                   out_oe, out_dp, out_dm, e.oe, e.dp, e.dm);
        end
        checks++;
        if (tx_err !== e.err || busy !== e.bsy) begin
          errors++;
          $display("FAIL %s err/busy cyc%0d: got %b/%b want %b/%b", name, cyc,
                   tx_err, busy, e.err, e.bsy);
        end
        if (e.chk_cnt) begin
          checks++;
          if (one_count !== e.cnt) begin
            errors++;
            $display("FAIL %s one_count cyc%0d: got %0d want %0d", name, cyc, one_count, e.cnt);
          end
        end
        prev = {e.oe, e.dp, e.dm};
        if (acc) idx++;
      end else begin
        checks++;
        if ({out_oe, out_dp, out_dm} !== prev || tx_err !== 1'b0) begin
          errors++;
          $display("FAIL %s stable cyc%0d: got oe/dp/dm %b%b%b err %b want %b err 0",
                   name, cyc, out_oe, out_dp, out_dm, tx_err, prev);
        end
      end
      cyc++;
    end
    bit_en   = 1'b0;
    in_valid = 1'b0;
    in_last  = 1'b0;
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL %s timeout: %0d slots left, want 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    RST = 1'b1; bit_en = 1'b1; in_valid = 1'b1; in_bit = 1'b0; in_last = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset in_ready: got %b want 0", in_ready);
    end
    @(negedge clk);
    @(negedge clk);
    checks++;
    if ({out_oe, out_dp, out_dm, busy, tx_err, one_count} !== {3'b010, 2'b00, 3'd0}) begin
      errors++;
      $display("FAIL reset values: got oe%b dp%b dm%b busy%b err%b cnt%0d want 0 1 0 0 0 0",
               out_oe, out_dp, out_dm, busy, tx_err, one_count);
    end
    RST = 1'b0; bit_en = 1'b0; in_valid = 1'b0;
  endtask

  task automatic test_sync();
    run_pkt("sync", 32'h80, 8, 0, 1);
  endtask

  task automatic test_stuff();
    run_pkt("stuff", 32'h0FF, 9, 0, 1);
  endtask

  task automatic test_stuff_last();
    run_pkt("stuff_last", 32'h3F, 6, 0, 1);
  endtask

  task automatic test_underrun();
    run_pkt("underrun", 32'h5, 3, 1, 1);
  endtask

  task automatic test_slow_strobe();
    run_pkt("slow", 32'h7EA5, 15, 0, 4);
  endtask

  task automatic test_reset_midpacket();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bit_en = 1'b1; in_valid = 1'b1; in_bit = 1'b0; in_last = 1'b0;
    end
    @(negedge clk);
    in_bit = 1'b1;
    RST    = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL midrst in_ready: got %b want 0", in_ready);
    end
    @(posedge clk);
    #1;
    checks++;
    if ({out_oe, out_dp, out_dm, busy, one_count} !== {3'b010, 1'b0, 3'd0}) begin
      errors++;
      $display("FAIL midrst values: got oe%b dp%b dm%b busy%b cnt%0d want 0 1 0 0 0",
               out_oe, out_dp, out_dm, busy, one_count);
    end
    @(negedge clk);
    RST = 1'b0; bit_en = 1'b0; in_valid = 1'b0;
    run_pkt("after_rst", 32'h80, 8, 0, 1);
  endtask

  task automatic test_back_to_back();
    run_pkt("b2b_a", 32'h1FF3, 13, 0, 1);
    run_pkt("b2b_b", 32'h2A, 6, 0, 2);
  endtask

  initial begin
    RST = 1'b0; bit_en = 1'b0; in_bit = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    test_reset();
    test_sync();
    test_stuff();
    test_stuff_last();
    test_underrun();
    test_slow_strobe();
    test_reset_midpacket();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
